aes_job_arbiter: RTL and testbench

//  Round-robin job scheduler sharing one aes core between NUM_REQ requesters. Each job carries key, key mode,

---
 rtl/aes_ctrl_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/aes_job_arbiter.sv | 172 +++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES job arbiter.
//   state_t      : job scheduler FSM states
//   KEY_MODE_*   : core key-mode encodings (1x selects 256-bit)
//   AES_BLK_W    : block width, AES_KEY_W : key port width
//   key_len()    : folds the two 256-bit encodings into one value for comparison
package aes_ctrl_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_KEY_W = 256;

  localparam logic [1:0] KEY_MODE_128 = 2'b00;
  localparam logic [1:0] KEY_MODE_192 = 2'b01;
  localparam logic [1:0] KEY_MODE_256 = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    KEY_START,
    KEY_FLUSH,
    KEY_WAIT,
    ISSUE,
    BUSY,
    RESP
  } state_t;

  // 2'b10 and 2'b11 both mean a 256-bit key, so they share one expanded schedule.
  function automatic logic [1:0] key_len(input logic [1:0] mode);
    logic [1:0] len;
    if (mode[1]) begin
      len = KEY_MODE_256;
    end else if (mode[0]) begin
      len = KEY_MODE_192;
    end else begin
      len = KEY_MODE_128;
    end
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot grant, first set request at or after ptr (wrapping)
//   idx   : binary index of the granted request
//   found : at least one request was set
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            found
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!found && req[IdxW'(cand)]) begin
        found              = 1'b1;
        grant[IdxW'(cand)] = 1'b1;
        idx                = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Round-robin job scheduler sharing one AES core between NUM_REQ requesters.
// Key expansion is skipped when the same requester reuses the key that is already expanded.
//   clk, reset                : clock, synchronous active-high reset
//   req_valid/ready           : per-requester job handshake (ready is one-hot, one cycle)
//   req_key_reuse/key/key_mode/ende/data : per-requester job payload
//   resp_valid/ready, resp_data : one-hot result handshake and result block
//   err_timeout, err_id       : abort pulse and requester of the aborted job
//   core_*                    : AES core interface (all core inputs driven here)
module aes_job_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned IdW  = $clog2(NUM_REQ),
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_key_reuse,
  input  logic [NUM_REQ*AES_KEY_W-1:0] req_key,
  input  logic [NUM_REQ*2-1:0]       req_key_mode,
  input  logic [NUM_REQ-1:0]         req_ende,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [AES_BLK_W-1:0]       resp_data,
  output logic                       err_timeout,
  output logic [IdW-1:0]             err_id,
  output logic                       core_enable,
  output logic                       core_start,
  output logic                       core_ende,
  output logic [1:0]                 core_key_mode,
  output logic [AES_KEY_W-1:0]       core_key,
  output logic                       core_data_valid,
  output logic [AES_BLK_W-1:0]       core_data,
  input  logic                       core_ready,
  input  logic                       core_key_ready,
  input  logic                       core_out_valid,
  input  logic [AES_BLK_W-1:0]       core_out_data
);

  state_t          state_q;
  logic [IdW-1:0]  ptr_q;
  logic [IdW-1:0]  id_q;
  logic [IdW-1:0]  owner_q;
  logic            key_valid_q;
  logic [CntW-1:0] cnt_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               gnt_found;
  logic               reuse_hit;
  logic               timeout_hit;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(gnt),
    .idx  (gnt_idx),
    .found(gnt_found)
  );

  // The expanded schedule in the core is only valid for the owner's key at the same key length.
  assign reuse_hit = key_valid_q && (owner_q == gnt_idx) && req_key_reuse[gnt_idx] &&
                     (key_len(req_key_mode[gnt_idx*2 +: 2]) == key_len(core_key_mode));

  assign timeout_hit = ((state_q == KEY_WAIT) || (state_q == BUSY)) &&
                       (cnt_q == CntW'(TIMEOUT_CYC - 1));

  assign req_ready   = (state_q == ARB) ? gnt : '0;
  assign err_timeout = timeout_hit;
  assign err_id      = timeout_hit ? id_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      id_q            <= '0;
      owner_q         <= '0;
      key_valid_q     <= 1'b0;
      cnt_q           <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      core_enable     <= 1'b0;
      core_start      <= 1'b0;
      core_ende       <= 1'b0;
      core_key_mode   <= '0;
      core_key        <= '0;
      core_data_valid <= 1'b0;
      core_data       <= '0;
    end else begin
      core_enable     <= 1'b1;
      core_start      <= 1'b0;
      core_data_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) state_q <= ARB;
        end
        ARB: begin
          if (gnt_found) begin
            core_key      <= req_key[gnt_idx*AES_KEY_W +: AES_KEY_W];
            core_key_mode <= req_key_mode[gnt_idx*2 +: 2];
            core_ende     <= req_ende[gnt_idx];
            core_data     <= req_data[gnt_idx*AES_BLK_W +: AES_BLK_W];
            id_q          <= gnt_idx;
            ptr_q         <= (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (reuse_hit) begin
              state_q <= ISSUE;
            end else begin
              state_q    <= KEY_START;
              core_start <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        KEY_START: begin
          key_valid_q <= 1'b0;
          state_q     <= KEY_FLUSH;
        end
        // core_key_ready may still show the previous schedule here.
        KEY_FLUSH: begin
          cnt_q   <= '0;
          state_q <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (timeout_hit) begin
            key_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (core_key_ready) begin
            key_valid_q <= 1'b1;
            owner_q     <= id_q;
            state_q     <= ISSUE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ISSUE: begin
          if (core_ready) begin
            core_data_valid <= 1'b1;
            cnt_q           <= '0;
            state_q         <= BUSY;
          end
        end
        BUSY: begin
          if (timeout_hit) begin
            key_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (core_out_valid) begin
            resp_data  <= core_out_data;
            resp_valid <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << id_q;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (|(resp_valid & resp_ready)) begin
            resp_valid <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: behavioural AES core plus a job-level reference model.
module tb_aes_job_arbiter;

  localparam int N  = 2;
  localparam int TO = 64;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_key_reuse = '0;
  logic [N*256-1:0] req_key = '0;
  logic [N*2-1:0]   req_key_mode = '0;
  logic [N-1:0]     req_ende = '0;
  logic [N*128-1:0] req_data = '0;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready = '0;
  logic [127:0]     resp_data;
  logic             err_timeout;
  logic [0:0]       err_id;
  logic             core_enable, core_start, core_ende, core_data_valid;
  logic [1:0]       core_key_mode;
  logic [255:0]     core_key;
  logic [127:0]     core_data;
  logic             core_ready = 1'b1;
  logic             core_key_ready = 1'b0;
  logic             core_out_valid = 1'b0;
  logic [127:0]     core_out_data = '0;

  always #5 clk = ~clk;

  aes_job_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_key_reuse  (req_key_reuse),
    .req_key        (req_key),
    .req_key_mode   (req_key_mode),
    .req_ende       (req_ende),
    .req_data       (req_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .err_timeout    (err_timeout),
    .err_id         (err_id),
    .core_enable    (core_enable),
    .core_start     (core_start),
    .core_ende      (core_ende),
    .core_key_mode  (core_key_mode),
    .core_key       (core_key),
    .core_data_valid(core_data_valid),
    .core_data      (core_data),
    .core_ready     (core_ready),
    .core_key_ready (core_key_ready),
    .core_out_valid (core_out_valid),
    .core_out_data  (core_out_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: which key the core holds and the round-robin pointer.
  bit       kv = 0;
  int       owner = 0;
  int       last_len = 0;
  int       rr_ptr = 0;

  // Core model controls and observations.
  bit       hang = 0;
  bit       rand_cr = 0;
  int       start_cnt = 0;
  int       kr_timer = 0;
  int       out_timer = 0;
  logic [255:0] exp_key = '0;
  logic [1:0]   exp_mode = '0;
  logic [127:0] pend = '0;

  // AES behaviour: the two known-answer vectors, otherwise a keyed scramble.
  function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [1:0] m,
                                           input logic e, input logic [127:0] d);
    logic [1:0] len;
    len = m[1] ? 2'd2 : m;
    if (k == K128 && len == 2'd0 && !e && d == PT) return CT128;
    if (k == K256 && len == 2'd2 && e && d == CT256) return PT;
    return {d[63:0], d[127:64]} ^ k[255:128] ^ {k[126:0], k[127]} ^ {124'd0, e, 1'b0, len};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic bit need_expand(input int r, input logic reuse, input logic [1:0] m);
    int len;
    len = m[1] ? 2 : int'(m);
    return !(kv && owner == r && reuse && len == last_len);
  endfunction

  always @(posedge clk) begin
    core_out_valid <= 1'b0;
    core_ready     <= rand_cr ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset) begin
      core_key_ready <= 1'b0;
      kr_timer       <= 0;
      out_timer      <= 0;
    end else begin
      if (core_start) begin
        start_cnt      <= start_cnt + 1;
        core_key_ready <= 1'b0;
        exp_key        <= core_key;
        exp_mode       <= core_key_mode;
        kr_timer       <= int'($urandom_range(3, 8));
      end else if (kr_timer == 1) begin
        core_key_ready <= 1'b1;
        kr_timer       <= 0;
      end else if (kr_timer > 1) begin
        kr_timer <= kr_timer - 1;
      end
      if (core_data_valid) begin
        pend      <= aes_ref(exp_key, exp_mode, core_ende, core_data);
        out_timer <= hang ? 0 : int'($urandom_range(2, 10));
      end else if (out_timer == 1) begin
        core_out_valid <= 1'b1;
        core_out_data  <= pend;
        out_timer      <= 0;
      end else if (out_timer > 1) begin
        out_timer <= out_timer - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [255:0] k, input logic [1:0] m,
                         input logic e, input logic [127:0] d, input logic reuse);
    req_key[r*256 +: 256] = k;
    req_key_mode[r*2 +: 2] = m;
    req_ende[r] = e;
    req_data[r*128 +: 128] = d;
    req_key_reuse[r] = reuse;
  endtask

  task automatic wait_grant(input int exp_g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 50);
    check("grant", req_ready, 256'(1) << exp_g);
  endtask

  // Waits for the result of requester r, checks it, optionally stalls, then accepts it.
  task automatic finish_job(input int r, input logic [255:0] k, input logic [1:0] m,
                            input logic e, input logic [127:0] exp_res, input bit exp_start,
                            input int starts0, input int hold);
    int n;
    int unstable;
    int other;
    n = 0;
    unstable = 0;
    other = (r + 1) % N;
    while (resp_valid == '0 && !err_timeout && n < 300) begin
      if (core_key !== k || core_key_mode !== m || core_ende !== e) unstable++;
      @(negedge clk);
      n++;
    end
    check("payload_stable", unstable, 0);
    check("resp_valid", resp_valid, 256'(1) << r);
    check("resp_data", resp_data, exp_res);
    if (hold > 0) req_valid[other] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 256'(1) << r);
      check("hold_data", resp_data, exp_res);
      check("hold_no_grant", req_ready, 0);
    end
    resp_ready[r] = 1'b1;
    if (hold > 0) req_valid[other] = 1'b0;
    @(negedge clk);
    resp_ready[r] = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("key_starts", start_cnt - starts0, exp_start);
    kv = 1;
    owner = r;
    last_len = m[1] ? 2 : int'(m);
  endtask

  task automatic do_job(input int r, input logic [255:0] k, input logic [1:0] m, input logic e,
                        input logic [127:0] d, input logic reuse, input int hold,
                        input bit chk_lat);
    bit exp_start;
    int starts0;
    int g;
    exp_start = need_expand(r, reuse, m);
    starts0 = start_cnt;
    set_req(r, k, m, e, d, reuse);
    req_valid[r] = 1'b1;
    g = rr_pick(req_valid, rr_ptr);
    wait_grant(g);
    rr_ptr = (g + 1) % N;
    @(negedge clk);
    req_valid[r] = 1'b0;
    if (chk_lat) begin
      check("issue_early", core_data_valid, 0);
      @(negedge clk);
      check("issue_lat2", core_data_valid, 1);
    end
    finish_job(r, k, m, e, aes_ref(k, m, e, d), exp_start, starts0, hold);
  endtask

  initial begin
    int n;
    int g;
    bit exp_start;
    bit seen_resp;
    int starts0;
    logic [255:0] last_key [N];
    bit have_last [N];
    int r;
    int ks;
    logic [255:0] k;
    logic [1:0] m;
    logic e;
    logic [127:0] d;
    logic reuse;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outs", {req_ready, resp_valid, err_timeout, err_id, core_enable, core_start,
                       core_data_valid, core_ende, core_key_mode}, 0);
    check("rst_key", core_key, 0);
    check("rst_data", {resp_data, core_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("enable_on", core_enable, 1);

    // AES-128 encrypt known answer, then a reuse hit with the issue latency checked.
    do_job(0, K128, 2'b00, 1'b0, PT, 1'b0, 0, 1'b0);
    do_job(0, K128, 2'b00, 1'b0, PT, 1'b1, 0, 1'b1);

    // Both requesters valid continuously with different keys: grants alternate.
    set_req(0, K128, 2'b00, 1'b0, PT, 1'b1);
    set_req(1, K256, 2'b10, 1'b1, CT256, 1'b1);
    req_valid = '1;
    for (int j = 0; j < 4; j++) begin
      g = rr_pick(req_valid, rr_ptr);
      exp_start = need_expand(g, 1'b1, req_key_mode[g*2 +: 2]);
      starts0 = start_cnt;
      wait_grant(g);
      rr_ptr = (g + 1) % N;
      @(negedge clk);
      finish_job(g, req_key[g*256 +: 256], req_key_mode[g*2 +: 2], req_ende[g],
                 aes_ref(req_key[g*256 +: 256], req_key_mode[g*2 +: 2], req_ende[g],
                         req_data[g*128 +: 128]), exp_start, starts0, 0);
    end
    req_valid = '0;

    // AES-256 decrypt known answer.
    do_job(1, K256, 2'b10, 1'b1, CT256, 1'b0, 0, 1'b0);

    // Random jobs with a stalling core.
    rand_cr = 1;
    have_last[0] = 0;
    have_last[1] = 0;
    for (int j = 0; j < 12; j++) begin
      r = int'($urandom_range(0, N - 1));
      ks = int'($urandom_range(0, 1));
      k = 256'(r * 4 + ks + 1) * 256'h1234_5678_9abc_def0_0fed_cba9_8765_4321_a5a5_5a5a;
      m = 2'($urandom_range(0, 3));
      e = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      reuse = (have_last[r] && last_key[r] == k) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_job(r, k, m, e, d, reuse, 0, 1'b0);
      last_key[r] = k;
      have_last[r] = 1;
    end
    rand_cr = 0;

    // Core never answers: timeout abort, then the key must be expanded again.
    hang = 1;
    exp_start = need_expand(0, 1'b1, 2'b00);
    starts0 = start_cnt;
    set_req(0, K128, 2'b00, 1'b0, PT, 1'b1);
    req_valid[0] = 1'b1;
    g = rr_pick(req_valid, rr_ptr);
    wait_grant(g);
    rr_ptr = (g + 1) % N;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!core_data_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_issue_seen", core_data_valid, 1);
    n = 0;
    seen_resp = 0;
    do begin
      @(negedge clk);
      n++;
      if (resp_valid != '0) seen_resp = 1;
    end while (!err_timeout && n < 100);
    check("to_latency", n, TO - 1);
    check("to_err_id", err_id, 0);
    @(negedge clk);
    check("to_pulse_1cyc", err_timeout, 0);
    check("to_no_resp", seen_resp, 0);
    check("to_key_starts", start_cnt - starts0, exp_start);
    kv = 0;
    hang = 0;
    do_job(0, K128, 2'b00, 1'b0, PT, 1'b1, 0, 1'b0);

    // Result held while resp_ready stays low, with the other requester waiting.
    do_job(1, K256, 2'b10, 1'b1, CT256, 1'b1, 10, 1'b0);

    // Reset in the middle of BUSY drops the job silently.
    hang = 1;
    set_req(1, K256, 2'b10, 1'b1, CT256, 1'b1);
    req_valid[1] = 1'b1;
    g = rr_pick(req_valid, rr_ptr);
    wait_grant(g);
    @(negedge clk);
    req_valid[1] = 1'b0;
    n = 0;
    while (!core_data_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outs", {req_ready, resp_valid, err_timeout, err_id, core_enable, core_start,
                          core_data_valid, core_ende, core_key_mode}, 0);
    check("midrst_key", core_key, 0);
    check("midrst_data", {resp_data, core_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    hang = 0;
    kv = 0;
    rr_ptr = 0;
    seen_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid != '0 || err_timeout) seen_resp = 1;
    end
    check("midrst_silent", seen_resp, 0);
    do_job(1, K256, 2'b10, 1'b1, CT256, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
